// File: rtl/muldiv_pkg.sv
// Shared MIPS SPECIAL-class encodings and HI/LO instruction decode for the
// multiply/divide unit.
package muldiv_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;

    typedef enum logic [3:0] {
        HL_NONE,
        HL_MULT,
        HL_MULTU,
        HL_DIV,
        HL_DIVU,
        HL_MFHI,
        HL_MFLO,
        HL_MTHI,
        HL_MTLO
    } hilo_op_e;

    function automatic hilo_op_e decode_hilo(input logic [5:0] opcode,
                                             input logic [5:0] funct);
        hilo_op_e op;
        op = HL_NONE;
        if (opcode == OP_SPECIAL) begin
            case (funct)
                FN_MULT:  op = HL_MULT;
                FN_MULTU: op = HL_MULTU;
                FN_DIV:   op = HL_DIV;
                FN_DIVU:  op = HL_DIVU;
                FN_MFHI:  op = HL_MFHI;
                FN_MFLO:  op = HL_MFLO;
                FN_MTHI:  op = HL_MTHI;
                FN_MTLO:  op = HL_MTLO;
                default:  op = HL_NONE;
            endcase
        end
        return op;
    endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, with combinational sign fixup of the final result.
module muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] dividend
);

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {remainder, remaining dividend bits / quotient bits}.
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   opnd_q;
    logic               div_q;
    logic               sign_a_q;
    logic               sign_b_q;

    logic             sign_a;
    logic             sign_b;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    assign sign_a = is_signed & a[WIDTH-1];
    assign sign_b = is_signed & b[WIDTH-1];
    assign a_mag  = sign_a ? -a : a;
    assign b_mag  = sign_b ? -b : b;

    logic [WIDTH-1:0] mul_addend;
    logic [WIDTH:0]   mul_sum;

    assign mul_addend = acc_q[0] ? opnd_q : {WIDTH{1'b0}};
    assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};

    // The shifted partial remainder carries one guard bit; when it is at least
    // the divisor the true difference fits in WIDTH bits, so a modulo
    // subtraction of the low bits is exact.
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;

    assign div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_q};
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_q;

    // NOTE: the datapath registers are reset as well, so an abort by reset
    // never leaves a stale partial product for the next operation to inherit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            div_q    <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
        end else if (load) begin
            div_q    <= is_div;
            sign_a_q <= sign_a;
            sign_b_q <= sign_b;
            opnd_q   <= is_div ? b_mag : a_mag;
            acc_q    <= {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
        end else if (step) begin
            if (div_q) begin
                acc_q <= {(div_ge ? div_diff : div_shift[WIDTH-1:0]),
                          acc_q[WIDTH-2:0], div_ge};
            end else begin
                acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
            end
        end
    end

    logic               neg_result;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;

    assign neg_result = sign_a_q ^ sign_b_q;
    assign product    = neg_result ? -acc_q : acc_q;
    assign quotient   = neg_result ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign remainder  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    assign res_hi   = div_q ? remainder : product[2*WIDTH-1:WIDTH];
    assign res_lo   = div_q ? quotient  : product[WIDTH-1:0];
    // Before any step, the loaded dividend magnitude re-signed is the original rs.
    assign dividend = sign_a_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: instruction decode, sequencing FSM, iteration
// counter, pipeline stall and the architectural HI/LO registers.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL   = 3'd1,
        S_DIV   = 3'd2,
        S_FIX   = 3'd3,
        S_DZERO = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q;

    hilo_op_e op;
    logic     hilo_op;
    logic     accept;

    assign op      = in_valid ? decode_hilo(opcode, funct) : HL_NONE;
    assign hilo_op = (op != HL_NONE);
    assign accept  = hilo_op && (state_q == S_IDLE) && !flush;
    assign stall   = hilo_op && (state_q != S_IDLE) && !flush;

    logic             core_load;
    logic             core_step;
    logic             core_is_div;
    logic             core_signed;
    logic [WIDTH-1:0] core_hi;
    logic [WIDTH-1:0] core_lo;
    logic [WIDTH-1:0] core_dividend;

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .rst       (rst),
        .load      (core_load),
        .step      (core_step),
        .is_div    (core_is_div),
        .is_signed (core_signed),
        .a         (rs_val),
        .b         (rt_val),
        .res_hi    (core_hi),
        .res_lo    (core_lo),
        .dividend  (core_dividend)
    );

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        core_load   = 1'b0;
        core_step   = 1'b0;
        core_is_div = 1'b0;
        core_signed = 1'b0;
        result      = '0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (op)
                        HL_MULT, HL_MULTU: begin
                            core_load   = 1'b1;
                            core_signed = (op == HL_MULT);
                            cnt_d       = CNT_W'(WIDTH - 1);
                            state_d     = S_MUL;
                        end
                        HL_DIV, HL_DIVU: begin
                            core_load   = 1'b1;
                            core_is_div = 1'b1;
                            core_signed = (op == HL_DIV);
                            cnt_d       = CNT_W'(WIDTH - 1);
                            state_d     = (rt_val == '0) ? S_DZERO : S_DIV;
                        end
                        HL_MTHI: hi_d   = rs_val;
                        HL_MTLO: lo_d   = rs_val;
                        HL_MFHI: result = hi_q;
                        HL_MFLO: result = lo_q;
                        default: ;
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                core_step = 1'b1;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_FIX: begin
                hi_d    = core_hi;
                lo_d    = core_lo;
                state_d = S_IDLE;
            end
            S_DZERO: begin
                hi_d    = core_dividend;
                lo_d    = '1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // An abort discards the in-flight operation and leaves HI/LO untouched.
        if (flush && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            core_step = 1'b0;
            hi_d      = hi_q;
            lo_d      = lo_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= (state_d != S_IDLE);
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a vector table of complete MULT/DIV ops plus
// hand-written sequences for stall, MTHI forwarding, flush and reset abort.
module tb_muldiv_unit;

    localparam int W = 32;

    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [5:0]   opcode = 6'h00;
    logic [5:0]   funct = 6'h00;
    logic [W-1:0] rs_val = '0;
    logic [W-1:0] rt_val = '0;
    logic         flush = 1'b0;
    logic         stall;
    logic         busy;
    logic [W-1:0] result;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .opcode   (opcode),
        .funct    (funct),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .flush    (flush),
        .stall    (stall),
        .busy     (busy),
        .result   (result),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        opcode   = 6'h00;
        funct    = fn;
        rs_val   = a;
        rt_val   = b;
    endtask

    task automatic clear_instr();
        in_valid = 1'b0;
        funct    = 6'h00;
        rs_val   = '0;
        rt_val   = '0;
    endtask

    typedef struct {
        string        name;
        logic [5:0]   fn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
        int           exp_busy;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        vecs[0]  = '{"multu_ones",   F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
        vecs[1]  = '{"mult_m3x7",    F_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 33};
        vecs[2]  = '{"div_m7d2",     F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[3]  = '{"divu_by0",     F_DIVU,  32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF, 1};
        vecs[4]  = '{"div_ovf",      F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[5]  = '{"multu_shift",  F_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 33};
        vecs[6]  = '{"divu_100d7",   F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33};
        vecs[7]  = '{"div_7dm2",     F_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
        vecs[8]  = '{"mult_minsq",   F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};
        vecs[9]  = '{"div_m1_by0",   F_DIV,   32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1};
        vecs[10] = '{"divu_small",   F_DIVU,  32'd5,        32'd10,       32'd5,        32'd0,        33};
        vecs[11] = '{"mult_max_m1",  F_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 33};

        // Reset state
        repeat (2) tick();
        check("reset_busy",   {31'b0, busy},  '0);
        check("reset_stall",  {31'b0, stall}, '0);
        check("reset_hi",     hi,             '0);
        check("reset_lo",     lo,             '0);
        check("reset_result", result,         '0);
        rst = 1'b0;
        tick();

        // Table-driven complete operations
        for (int i = 0; i < 12; i++) begin
            set_instr(vecs[i].fn, vecs[i].a, vecs[i].b);
            tick();
            clear_instr();
            n = 0;
            while (busy && n < 100) begin
                tick();
                n++;
            end
            check({vecs[i].name, "_busy_cycles"}, n, vecs[i].exp_busy);
            check({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
            check({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
            set_instr(F_MFLO, '0, '0);
            #1;
            check({vecs[i].name, "_mflo"}, result, vecs[i].exp_lo);
            set_instr(F_MFHI, '0, '0);
            #1;
            check({vecs[i].name, "_mfhi"}, result, vecs[i].exp_hi);
            clear_instr();
            tick();
        end

        // Dependent MFLO right after MULT stalls for WIDTH+1 cycles
        set_instr(F_MULT, 32'd6, 32'd7);
        tick();
        set_instr(F_MFLO, '0, '0);
        #1;
        n = 0;
        while (stall && n < 100) begin
            tick();
            n++;
        end
        check("dep_mflo_stall_cycles", n, 33);
        check("dep_mflo_result", result, 32'd42);
        check("dep_mflo_busy", {31'b0, busy}, '0);
        clear_instr();
        tick();

        // MTHI followed back-to-back by MFHI
        set_instr(F_MTHI, 32'h00001234, '0);
        #1;
        check("mthi_stall", {31'b0, stall}, '0);
        tick();
        set_instr(F_MFHI, '0, '0);
        #1;
        check("mfhi_fwd_stall", {31'b0, stall}, '0);
        check("mfhi_fwd_result", result, 32'h00001234);
        clear_instr();
        tick();

        // Flush mid-divide leaves HI/LO at their prior values
        set_instr(F_MTHI, 32'h0000AAAA, '0);
        tick();
        set_instr(F_MTLO, 32'h00005555, '0);
        tick();
        set_instr(F_DIVU, 32'd1000, 32'd3);
        tick();
        clear_instr();
        repeat (9) tick();
        set_instr(F_MFHI, '0, '0);
        #1;
        check("inflight_stall", {31'b0, stall}, 32'd1);
        check("inflight_result", result, '0);
        flush = 1'b1;
        #1;
        check("flush_stall", {31'b0, stall}, '0);
        tick();
        flush = 1'b0;
        clear_instr();
        #1;
        check("flush_busy", {31'b0, busy}, '0);
        check("flush_hi", hi, 32'h0000AAAA);
        check("flush_lo", lo, 32'h00005555);
        repeat (40) tick();
        check("flush_hi_later", hi, 32'h0000AAAA);
        check("flush_lo_later", lo, 32'h00005555);

        // Flush in IDLE blocks accept
        set_instr(F_MTHI, 32'h00009999, '0);
        flush = 1'b1;
        tick();
        set_instr(F_MULT, 32'd3, 32'd3);
        tick();
        flush = 1'b0;
        clear_instr();
        #1;
        check("flush_idle_hi", hi, 32'h0000AAAA);
        check("flush_idle_busy", {31'b0, busy}, '0);

        // Reset mid-multiply clears immediately
        set_instr(F_MULTU, 32'hFFFFFFFF, 32'h00000003);
        tick();
        clear_instr();
        repeat (5) tick();
        check("pre_rst_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_busy", {31'b0, busy}, '0);
        check("rst_mid_hi", hi, '0);
        check("rst_mid_lo", lo, '0);
        tick();
        rst = 1'b0;
        repeat (40) tick();
        check("post_rst_lo", lo, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
